// File: rtl/sram_arb2_ctrl.sv
// Two-port round-robin controller in front of one single-port 256x32 SRAM macro.
// Ports: clk/reset; per-port req_valid/req_ready/req_we/req_addrN/req_wdataN;
// resp_valid/resp_rdata back to the requesters; init_done; mem_* pins to the macro.
module sram_arb2_ctrl #(
    parameter int BITS          = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int WORD_DEPTH    = 256,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [BITS-1:0]       req_wdata0,
    input  logic [BITS-1:0]       req_wdata1,
    output logic [1:0]            resp_valid,
    output logic [BITS-1:0]       resp_rdata,
    output logic                  init_done,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BITS-1:0]       mem_wd,
    input  logic [BITS-1:0]       mem_rd
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(WORD_DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH:0]   init_cnt;
    logic                  last_grant;
    logic [1:0]            resp_q;
    logic [1:0]            grant;
    logic                  run;

    // Outputs are forced to their idle values while reset is held.
    assign run = (state == RUN) && !reset;

    // Tie goes to the port that did not win the previous accepted transfer.
    always_comb begin
        grant = 2'b00;
        if (run) begin
            grant[0] = req_valid[0] && (!req_valid[1] || last_grant);
            grant[1] = req_valid[1] && (!req_valid[0] || !last_grant);
        end
    end

    always_comb begin
        mem_ce   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (!reset && state == INIT) begin
            mem_ce   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = init_cnt[ADDR_WIDTH-1:0];
        end else if (grant[0]) begin
            mem_ce   = 1'b1;
            mem_we   = req_we[0];
            mem_addr = req_addr0;
            mem_wd   = req_wdata0;
        end else if (grant[1]) begin
            mem_ce   = 1'b1;
            mem_we   = req_we[1];
            mem_addr = req_addr1;
            mem_wd   = req_wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (INIT_ON_RESET) begin
                state <= INIT;
            end else begin
                state <= RUN;
            end
            init_cnt   <= '0;
            last_grant <= 1'b1;
            resp_q     <= 2'b00;
        end else begin
            // Macro read data appears the cycle after the accepting edge.
            resp_q <= grant & ~req_we;
            if (|grant) begin
                last_grant <= grant[1];
            end
            unique case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_ADDR) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                end
                default: state <= INIT;
            endcase
        end
    end

    assign req_ready  = grant;
    assign resp_valid = resp_q & {2{~reset}};
    assign resp_rdata = mem_rd;
    assign init_done  = run;

endmodule
